l3_world_store: RTL

L3_WORLD_STORE -- requirements
Module: l3_world_store

---
 rtl/l3_world_store.sv | 102 ++++++++++
 1 files changed

// File: rtl/l3_world_store.sv
// Level-3 voxel world store: 32K x 3-bit single-port block RAM behind a
// four-state controller (terrain init, idle, fixed 2-cycle read wait, response).
module l3_world_store #(
  parameter int unsigned GROUND_LEVEL = 8,
  parameter int unsigned GROUND_TYPE  = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [14:0] l3_addr,
  input  logic        l3_read_enable,
  output logic [2:0]  l3_out,
  output logic        l3_valid,
  input  logic        wr_enable,
  input  logic [14:0] wr_addr,
  input  logic [2:0]  wr_type,
  output logic        wr_ready,
  output logic        init_done
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [14:0] init_cnt_q, init_cnt_d;
  logic        wait_cnt_q, wait_cnt_d;
  logic [2:0]  out_q, out_d;

  logic [2:0]  mem [32768];
  logic [2:0]  rd1_q, rd2_q;

  logic        ram_we;
  logic [14:0] ram_addr;
  logic [2:0]  ram_wdata;
  logic        init_ground;

  assign init_ground = 32'(init_cnt_q[9:5]) < GROUND_LEVEL;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    out_d      = out_q;
    ram_we     = 1'b0;
    ram_addr   = l3_addr;
    ram_wdata  = wr_type;
    case (state_q)
      S_INIT: begin
        ram_we     = 1'b1;
        ram_addr   = init_cnt_q;
        ram_wdata  = init_ground ? 3'(GROUND_TYPE) : '0;
        init_cnt_d = init_cnt_q + 15'd1;
        if (init_cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        // A write owns the single RAM port; a held read retries next cycle.
        if (wr_enable) begin
          ram_we   = 1'b1;
          ram_addr = wr_addr;
        end else if (l3_read_enable) begin
          ram_addr   = l3_addr;
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q) begin
          out_d   = rd2_q;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      out_q      <= out_d;
    end
  end

  // Block RAM with two output register stages; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd1_q <= mem[ram_addr];
    rd2_q <= rd1_q;
  end

  assign l3_out    = out_q;
  assign l3_valid  = (state_q == S_RESP);
  assign wr_ready  = (state_q == S_IDLE);
  assign init_done = (state_q != S_INIT);

endmodule
